// File: rtl/ibex_bcp_checker.sv
// ibex_bcp_checker: multi-cycle bound check of the EX adder result against
// a set of base/limit regions. A fixed number of regions is compared per
// cycle and the scan always runs to the end, so timing never depends on
// the address or on the region contents. The result is held for ID until
// it is acknowledged or the check is killed.
module ibex_bcp_checker #(
    parameter int unsigned BCPNumRegions   = 4,
    parameter int unsigned RegionsPerCycle = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_i,
    output logic                            ready_o,
    input  logic [31:0]                     addr_i,
    input  logic [1:0]                      size_i,
    input  logic [1:0]                      type_i,
    input  logic                            kill_i,
    input  logic [BCPNumRegions-1:0][31:0]  bcp_base_i,
    input  logic [BCPNumRegions-1:0][31:0]  bcp_limit_i,
    input  logic [BCPNumRegions-1:0]        bcp_en_i,
    input  logic [BCPNumRegions-1:0]        bcp_r_i,
    input  logic [BCPNumRegions-1:0]        bcp_w_i,
    input  logic                            bcp_enforce_i,
    output logic                            valid_o,
    input  logic                            ack_i,
    output logic                            load_err_o,
    output logic                            store_err_o,
    output logic                            arith_err_o
);

    localparam int unsigned IdxW = (BCPNumRegions > 1) ? $clog2(BCPNumRegions) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BCPNumRegions - RegionsPerCycle);
    localparam logic [IdxW-1:0] IdxStep = IdxW'(RegionsPerCycle);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Last byte offset of the access: arith is always a 1-byte probe and the
    // reserved size encoding behaves like a word.
    function automatic logic [1:0] len_m1(input logic [1:0] size, input logic [1:0] typ);
        logic [1:0] res;
        if (typ[1]) begin
            res = 2'd0;
        end else begin
            case (size)
                2'd0:    res = 2'd0;
                2'd1:    res = 2'd1;
                default: res = 2'd3;
            endcase
        end
        return res;
    endfunction

    // One region permits the access: enabled, well-formed, fully covers
    // [lo,hi] and grants the permission the access type needs.
    function automatic logic region_ok(
        input logic        en,
        input logic        r,
        input logic        w,
        input logic [31:0] base,
        input logic [31:0] limit,
        input logic [31:0] lo,
        input logic [31:0] hi,
        input logic [1:0]  typ
    );
        logic match;
        logic perm;
        match = en & (base <= limit) & (base <= lo) & (hi <= limit);
        case (typ)
            2'd0:    perm = r;
            2'd1:    perm = w;
            default: perm = 1'b1;
        endcase
        return match & perm;
    endfunction

    // One-hot error vector {load, store, arith} selected by access type.
    function automatic logic [2:0] err_onehot(input logic [1:0] typ);
        logic [2:0] res;
        case (typ)
            2'd0:    res = 3'b100;
            2'd1:    res = 3'b010;
            default: res = 3'b001;
        endcase
        return res;
    endfunction

    state_e            state_r;
    state_e            state_next_s;
    logic              accept_s;
    logic              ready_r;
    logic              valid_r;
    logic [2:0]        err_r;
    logic [2:0]        err_next_s;
    logic [31:0]       addr_r;
    logic [31:0]       end_r;
    logic              wrap_r;
    logic [1:0]        type_r;
    logic              hit_r;
    logic [IdxW-1:0]   idx_r;
    logic [IdxW-1:0]   ridx_s;
    logic              grp_pass_s;
    logic [32:0]       end33_s;
    logic              fail_s;

    // End address of the incoming access, one bit wider to expose wrap.
    always_comb begin
        end33_s = {1'b0, addr_i} + 33'(len_m1(size_i, type_i));
    end

    // Compare the current group of regions against the captured range.
    always_comb begin
        grp_pass_s = 1'b0;
        ridx_s     = idx_r;
        for (int j = 0; j < int'(RegionsPerCycle); j++) begin
            ridx_s = idx_r + IdxW'(j);
            if (region_ok(bcp_en_i[ridx_s], bcp_r_i[ridx_s], bcp_w_i[ridx_s],
                          bcp_base_i[ridx_s], bcp_limit_i[ridx_s],
                          addr_r, end_r, type_r)) begin
                grp_pass_s = 1'b1;
            end else begin
                grp_pass_s = grp_pass_s;
            end
        end
    end

    // Final verdict once the last group is folded in.
    always_comb begin
        fail_s = wrap_r | ~(hit_r | grp_pass_s);
    end

    // Next-state and next-error logic.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        err_next_s   = 3'b000;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    accept_s = 1'b1;
                    if (bcp_enforce_i) begin
                        state_next_s = ST_SCAN;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (kill_i) begin
                    state_next_s = ST_IDLE;
                end else if (idx_r == LastIdx) begin
                    state_next_s = ST_DONE;
                    if (fail_s) begin
                        err_next_s = err_onehot(type_r);
                    end else begin
                        err_next_s = 3'b000;
                    end
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (kill_i || ack_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                    err_next_s   = err_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake outputs, errors and capture/accumulator registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            err_r   <= 3'b000;
            addr_r  <= 32'h0000_0000;
            end_r   <= 32'h0000_0000;
            wrap_r  <= 1'b0;
            type_r  <= 2'd0;
            hit_r   <= 1'b0;
            idx_r   <= '0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            valid_r <= (state_next_s == ST_DONE);
            err_r   <= err_next_s;
            if (accept_s) begin
                addr_r <= addr_i;
                end_r  <= end33_s[31:0];
                wrap_r <= end33_s[32];
                type_r <= type_i;
                hit_r  <= 1'b0;
                idx_r  <= '0;
            end else if (state_r == ST_SCAN) begin
                hit_r <= hit_r | grp_pass_s;
                idx_r <= idx_r + IdxStep;
            end else begin
                hit_r <= hit_r;
                idx_r <= idx_r;
            end
        end
    end

    assign ready_o     = ready_r;
    assign valid_o     = valid_r;
    assign load_err_o  = err_r[2];
    assign store_err_o = err_r[1];
    assign arith_err_o = err_r[0];

endmodule
